// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared types, defaults and width helpers for the Sherman-Morrison pixel source
package sm_pkg;

  // Defaults shared with the system-level bench.
  localparam int SM_DATA_WIDTH     = 16;
  localparam int SM_NUM_BANDS      = 16;
  localparam int SM_NUM_PIXELS     = 64;
  localparam int SM_DIVIDEND_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV    = 2'd1,
    STREAM = 2'd2,
    FIN    = 2'd3
  } state_t;

  typedef logic [SM_DATA_WIDTH-1:0] sample_t;

  // Width of a counter running 0..n-1; never less than one bit so tiny frames stay legal.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_beat_hold.sv
// rtl/axis_beat_hold.sv - single-beat AXI-Stream output register with pause sampling
module axis_beat_hold #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  pause_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  tready_i,
  output logic                  launch_ok_o,
  output logic                  accept_o,
  output logic                  tvalid_o,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tlast_o
);

  logic                  tvalid_q;
  logic                  tlast_q;
  logic [DATA_WIDTH-1:0] tdata_q;

  // A beat transfers on valid&ready; a new beat may enter only when the slot is empty
  // or draining this cycle, and pause is only consulted at exactly those points.
  always_comb begin
    accept_o    = tvalid_q && tready_i;
    launch_ok_o = !pause_i && (!tvalid_q || tready_i);
  end

  // Hold register: a pending beat stays frozen until it is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else if (load_i && launch_ok_o) begin
      tvalid_q <= 1'b1;
      tlast_q  <= last_i;
      tdata_q  <= data_i;
    end else if (accept_o) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end
  end

  assign tvalid_o = tvalid_q;
  assign tdata_o  = tdata_q;
  assign tlast_o  = tlast_q;

endmodule

// File: rtl/sm_pixel_source.sv
// rtl/sm_pixel_source.sv - AXI-Stream pixel vector source with per-frame dividend pulse
module sm_pixel_source
  import sm_pkg::*;
#(
  parameter int                        DATA_WIDTH     = SM_DATA_WIDTH,
  parameter int                        NUM_BANDS      = SM_NUM_BANDS,
  parameter int                        NUM_PIXELS     = SM_NUM_PIXELS,
  parameter int                        DIVIDEND_WIDTH = SM_DIVIDEND_WIDTH,
  parameter logic [DIVIDEND_WIDTH-1:0] DIVIDEND_VALUE = 8'd16,
  parameter logic [DATA_WIDTH-1:0]     SEED           = '0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      start,
  input  logic                      pause,
  output logic [DATA_WIDTH-1:0]     M_AXIS_tdata,
  output logic                      M_AXIS_tvalid,
  input  logic                      M_AXIS_tready,
  output logic                      M_AXIS_tlast,
  output logic [DIVIDEND_WIDTH-1:0] M_AXIS_DIVIDEND_tdata,
  output logic                      M_AXIS_DIVIDEND_tvalid,
  output logic                      busy,
  output logic                      done
);

  localparam int              BW        = cnt_width(NUM_BANDS);
  localparam int              PW        = cnt_width(NUM_PIXELS);
  localparam logic [BW-1:0]   BAND_MAX  = BW'(NUM_BANDS - 1);
  localparam logic [PW-1:0]   PIX_MAX   = PW'(NUM_PIXELS - 1);

  state_t                    state_q;
  logic [BW-1:0]             band_q, band_d;
  logic [PW-1:0]             pix_q, pix_d;
  logic [DATA_WIDTH-1:0]     acc_q, acc_d;
  logic                      busy_q;
  logic                      done_q;
  logic                      div_valid_q;
  logic [DIVIDEND_WIDTH-1:0] div_data_q;

  logic accept;
  logic launch_ok;
  logic load;
  logic hold_en;
  logic final_accept;
  logic beat_last;

  // Counters point at the beat currently pending (or next to launch); they advance on
  // each handshake, and the post-handshake values feed a beat launched in that same cycle.
  always_comb begin
    band_d       = band_q;
    pix_d        = pix_q;
    acc_d        = acc_q;
    final_accept = accept && (state_q == STREAM) && (band_q == BAND_MAX) && (pix_q == PIX_MAX);
    if (accept) begin
      acc_d = acc_q + DATA_WIDTH'(1);
      if (band_q == BAND_MAX) begin
        band_d = '0;
        pix_d  = (pix_q == PIX_MAX) ? '0 : pix_q + PW'(1);
      end else begin
        band_d = band_q + BW'(1);
      end
    end
    beat_last = (band_d == BAND_MAX);
    // The first beat is launched from DIV so it appears two cycles after start.
    hold_en   = (state_q == DIV) || ((state_q == STREAM) && !final_accept);
    load      = hold_en && launch_ok;
  end

  axis_beat_hold #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .pause_i     (pause),
    .load_i      (load),
    .data_i      (acc_d),
    .last_i      (beat_last),
    .tready_i    (M_AXIS_tready),
    .launch_ok_o (launch_ok),
    .accept_o    (accept),
    .tvalid_o    (M_AXIS_tvalid),
    .tdata_o     (M_AXIS_tdata),
    .tlast_o     (M_AXIS_tlast)
  );

  // Frame sequencer with registered dividend, busy and done outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      band_q      <= '0;
      pix_q       <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_valid_q <= 1'b0;
      div_data_q  <= '0;
    end else begin
      done_q      <= 1'b0;
      div_valid_q <= 1'b0;
      div_data_q  <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= DIV;
            busy_q      <= 1'b1;
            div_valid_q <= 1'b1;
            div_data_q  <= DIVIDEND_VALUE;
            band_q      <= '0;
            pix_q       <= '0;
            acc_q       <= SEED;
          end
        end
        DIV: begin
          state_q <= STREAM;
        end
        STREAM: begin
          band_q <= band_d;
          pix_q  <= pix_d;
          acc_q  <= acc_d;
          if (final_accept) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign M_AXIS_DIVIDEND_tvalid = div_valid_q;
  assign M_AXIS_DIVIDEND_tdata  = div_data_q;
  assign busy                   = busy_q;
  assign done                   = done_q;

endmodule

// File: tb/tb_sm_pixel_source.sv
// tb/tb_sm_pixel_source.sv - self-checking bench for sm_pixel_source
module tb_sm_pixel_source;
  import sm_pkg::*;

  localparam int          NB    = 4;
  localparam int          NP    = 2;
  localparam int          TOTAL = NB * NP;
  localparam logic [15:0] SEED0 = 16'h0000;
  localparam logic [15:0] SEED1 = 16'hFFFE;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic start   = 1'b0;
  logic pause   = 1'b0;
  logic tready  = 1'b0;

  sample_t    td0, td1;
  logic       tv0, tv1, tl0, tl1, dv0, dv1, b0, b1, dn0, dn1;
  logic [7:0] dd0, dd1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: frame progress expressed as beats sent and the index of the beat on the bus.
  bit m_busy  = 1'b0;
  bit m_div   = 1'b0;
  bit m_done  = 1'b0;
  bit m_valid = 1'b0;
  int m_idx   = 0;
  int m_sent  = 0;

  sample_t     obs0[$];
  logic [16:0] obs1[$];

  always #5 aclk = ~aclk;

  sm_pixel_source #(
    .DATA_WIDTH(16), .NUM_BANDS(NB), .NUM_PIXELS(NP), .DIVIDEND_WIDTH(8),
    .DIVIDEND_VALUE(8'd16), .SEED(SEED0)
  ) u0 (
    .aclk(aclk), .aresetn(aresetn), .start(start), .pause(pause),
    .M_AXIS_tdata(td0), .M_AXIS_tvalid(tv0), .M_AXIS_tready(tready), .M_AXIS_tlast(tl0),
    .M_AXIS_DIVIDEND_tdata(dd0), .M_AXIS_DIVIDEND_tvalid(dv0), .busy(b0), .done(dn0)
  );

  sm_pixel_source #(
    .DATA_WIDTH(16), .NUM_BANDS(NB), .NUM_PIXELS(NP), .DIVIDEND_WIDTH(8),
    .DIVIDEND_VALUE(8'd16), .SEED(SEED1)
  ) u1 (
    .aclk(aclk), .aresetn(aresetn), .start(start), .pause(pause),
    .M_AXIS_tdata(td1), .M_AXIS_tvalid(tv1), .M_AXIS_tready(tready), .M_AXIS_tlast(tl1),
    .M_AXIS_DIVIDEND_tdata(dd1), .M_AXIS_DIVIDEND_tvalid(dv1), .busy(b1), .done(dn1)
  );

  task automatic check_outs(input string nm, input logic [15:0] seed, input logic v,
                            input logic [15:0] d, input logic l, input logic dv,
                            input logic [7:0] dd, input logic b, input logic dn);
    logic [15:0] ed;
    logic [7:0]  edd;
    logic        el;
    bit          bad;
    ed  = seed + 16'(m_idx);
    el  = ((m_idx % NB) == NB - 1);
    edd = m_div ? 8'd16 : 8'd0;
    bad = (v !== m_valid) || (m_valid && ((d !== ed) || (l !== el))) ||
          (dv !== m_div) || (dd !== edd) || (b !== m_busy) || (dn !== m_done);
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL model_%s t=%0t: got v=%b d=%h l=%b dv=%b dd=%h busy=%b done=%b, required v=%b d=%h l=%b dv=%b dd=%h busy=%b done=%b",
               nm, $time, v, d, l, dv, dd, b, dn, m_valid, ed, el, m_div, edd, m_busy, m_done);
    end
  endtask

  // Advance the model across one rising edge using the inputs presented for that edge.
  function automatic void step_model();
    bit hs;
    hs = m_valid && (tready === 1'b1);
    if (hs) m_sent++;
    if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy  = 1'b1;
        m_div   = 1'b1;
        m_sent  = 0;
        m_valid = 1'b0;
      end
    end else if (m_div) begin
      m_div   = 1'b0;
      m_idx   = 0;
      m_valid = !pause;
    end else if (hs && (m_sent == TOTAL)) begin
      m_valid = 1'b0;
      m_done  = 1'b1;
    end else if (!m_valid || hs) begin
      m_valid = !pause;
      m_idx   = m_sent;
    end
  endfunction

  // Compare both instances against the model every cycle, away from the active edge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      m_busy = 1'b0; m_div = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_idx = 0; m_sent = 0;
    end
    check_outs("seed0", SEED0, tv0, td0, tl0, dv0, dd0, b0, dn0);
    check_outs("seedFFFE", SEED1, tv1, td1, tl1, dv1, dd1, b1, dn1);
    if (aresetn && tv0 && tready) obs0.push_back(td0);
    if (aresetn && tv1 && tready) obs1.push_back({tl1, td1});
    if (aresetn) step_model();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %h required %h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k;
    k = 0;
    while (b0 && k < budget) begin
      tick();
      k++;
    end
    if (b0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout t=%0t: got busy=1 required busy=0 within %0d cycles", nm, $time, budget);
    end
  endtask

  task automatic wait_beat(input string nm, input logic [15:0] val, input int budget);
    int k;
    k = 0;
    while (!(tv0 && td0 == val) && k < budget) begin
      tick();
      k++;
    end
    chk({nm, "_reached"}, 32'(tv0 && td0 == val), 32'd1);
  endtask

  task automatic check_seq0(input string nm);
    chk({nm, "_count"}, 32'(obs0.size()), 32'(TOTAL));
    for (int i = 0; i < obs0.size() && i < TOTAL; i++)
      chk({nm, "_data"}, 32'(obs0[i]), 32'(i));
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("reset_tvalid", 32'(tv0), 32'd0);
    chk("reset_busy", 32'(b0), 32'd0);
    chk("reset_div_valid", 32'(dv0), 32'd0);
    aresetn = 1'b1;
    repeat (2) tick();

    // Back-to-back frame with the exact cycle timing pinned
    obs0.delete(); obs1.delete();
    tready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("A_div_valid", 32'(dv0), 32'd1);
    chk("A_div_data", 32'(dd0), 32'd16);
    chk("A_busy", 32'(b0), 32'd1);
    chk("A_tvalid_early", 32'(tv0), 32'd0);
    tick();
    for (int i = 0; i < TOTAL; i++) begin
      chk("A_tvalid", 32'(tv0), 32'd1);
      chk("A_tdata", 32'(td0), 32'(i));
      chk("A_tlast", 32'(tl0), 32'((i % NB) == NB - 1));
      tick();
    end
    chk("A_done", 32'(dn0), 32'd1);
    chk("A_busy_fin", 32'(b0), 32'd1);
    tick();
    chk("A_done_low", 32'(dn0), 32'd0);
    chk("A_busy_low", 32'(b0), 32'd0);
    check_seq0("A_seq");
    chk("D_count", 32'(obs1.size()), 32'(TOTAL));
    if (obs1.size() >= 4) begin
      chk("D_beat0", 32'(obs1[0]), 32'h0_FFFE);
      chk("D_beat1", 32'(obs1[1]), 32'h0_FFFF);
      chk("D_beat2", 32'(obs1[2]), 32'h0_0000);
      chk("D_beat3", 32'(obs1[3]), 32'h1_0001);
    end

    // tready pattern 1,0,0,1: pending beats must hold steady
    obs0.delete();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 80 && b0; c++) begin
      tready = ((c % 4) == 0) || ((c % 4) == 3);
      if (tv0 && !tready) begin
        logic [15:0] hd;
        logic        hl;
        hd = td0;
        hl = tl0;
        tick();
        chk("B_hold_valid", 32'(tv0), 32'd1);
        chk("B_hold_data", 32'(td0), 32'(hd));
        chk("B_hold_last", 32'(tl0), 32'(hl));
      end else begin
        tick();
      end
    end
    tready = 1'b1;
    wait_idle("B", 20);
    check_seq0("B_seq");

    // pause between beats, then pause while a beat is stalled
    obs0.delete();
    start = 1'b1; tick(); start = 1'b0;
    wait_beat("C_beat2", 16'd2, 20);
    pause = 1'b1;
    tick();
    repeat (3) begin
      chk("C_paused_tvalid", 32'(tv0), 32'd0);
      tick();
    end
    pause = 1'b0;
    tick();
    chk("C_resume_valid", 32'(tv0), 32'd1);
    chk("C_resume_data", 32'(td0), 32'd3);
    wait_beat("C_beat5", 16'd5, 20);
    tready = 1'b0;
    pause  = 1'b1;
    repeat (3) begin
      tick();
      chk("C_stall_valid", 32'(tv0), 32'd1);
      chk("C_stall_data", 32'(td0), 32'd5);
    end
    tready = 1'b1;
    pause  = 1'b0;
    wait_idle("C", 20);
    check_seq0("C_seq");

    // start ignored during STREAM and in FIN, accepted the cycle after
    obs0.delete();
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 30 && !dn0; k++) tick();
    chk("E_done_seen", 32'(dn0), 32'd1);
    check_seq0("E_seq_first");
    obs0.delete();
    start = 1'b1;
    tick();
    chk("E_fin_start_busy", 32'(b0), 32'd0);
    chk("E_fin_start_div", 32'(dv0), 32'd0);
    tick();
    start = 1'b0;
    chk("E_restart_div", 32'(dv0), 32'd1);
    chk("E_restart_div_data", 32'(dd0), 32'd16);
    wait_idle("E", 30);
    check_seq0("E_seq_second");

    // asynchronous reset mid-pixel
    obs0.delete();
    start = 1'b1; tick(); start = 1'b0;
    wait_beat("F_beat5", 16'd5, 20);
    #2 aresetn = 1'b0;
    #1;
    chk("F_async_tvalid", 32'(tv0), 32'd0);
    chk("F_async_tdata", 32'(td0), 32'd0);
    chk("F_async_tlast", 32'(tl0), 32'd0);
    chk("F_async_busy", 32'(b0), 32'd0);
    chk("F_async_tvalid_u1", 32'(tv1), 32'd0);
    tick(); tick();
    aresetn = 1'b1;
    repeat (3) tick();
    chk("F_idle_busy", 32'(b0), 32'd0);
    chk("F_idle_tvalid", 32'(tv0), 32'd0);
    obs0.delete();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("F_first_valid", 32'(tv0), 32'd1);
    chk("F_first_data", 32'(td0), 32'(SEED0));
    wait_idle("F", 20);
    check_seq0("F_seq");

    // randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      tready  = ($urandom_range(0, 9) < 7);
      pause   = ($urandom_range(0, 9) < 2);
      start   = ($urandom_range(0, 15) == 0);
      aresetn = ($urandom_range(0, 399) != 0);
      tick();
    end
    aresetn = 1'b1;
    start   = 1'b0;
    pause   = 1'b0;
    tready  = 1'b1;
    wait_idle("R", 100);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
